// File: rtl/avg_out_stage.sv
// FIFO-buffered sum-to-average output stage.
// Rounds sum/2^SHIFT, saturates to OUT_W bits, tracks running peak.
module avg_out_stage #(
  parameter int DEPTH = 4,
  parameter int IN_W  = 11,
  parameter int OUT_W = 8,
  parameter int SHIFT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       din_busy,
  input  logic                       din_vld,
  input  logic [IN_W-1:0]            din_data,
  input  logic                       dout_busy,
  output logic                       dout_vld,
  output logic [OUT_W-1:0]           dout_data,
  output logic [OUT_W-1:0]           peak,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [IN_W:0] RND =
    (IN_W+1)'(2 ** (SHIFT - 1));
  localparam logic [IN_W:0] MAXV =
    (IN_W+1)'((2 ** OUT_W) - 1);

  logic [IN_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;
  logic [IN_W:0]   rsum;
  logic [IN_W:0]   avg;

  assign din_busy = (level == FULL);
  assign dout_vld = (level != '0);
  assign push     = din_vld && !din_busy;
  assign pop      = dout_vld && !dout_busy;

  always_comb begin
    rsum = {1'b0, mem[rd_ptr]} + RND;
    avg  = rsum >> SHIFT;
    if (avg > MAXV)
      dout_data = '1;
    else
      dout_data = avg[OUT_W-1:0];
  end

  // Storage is not reset; level gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && push)
      mem[wr_ptr] <= din_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      peak   <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (pop && (dout_data > peak))
        peak <= dout_data;
    end
  end

endmodule

// File: tb/tb_avg_out_stage.sv
// Randomized bench for avg_out_stage.
// Reference: queue of sums, averages by plain arithmetic.
module tb_avg_out_stage;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din_vld = 1'b0;
  logic [10:0] din_data = '0;
  logic        dout_busy = 1'b0;
  logic        din_busy;
  logic        dout_vld;
  logic [7:0]  dout_data;
  logic [7:0]  peak;
  logic [2:0]  level;

  int vectors = 0;
  int miscompares = 0;
  int mq[$];
  int mpk = 0;

  avg_out_stage dut (
    .clk(clk), .rst(rst),
    .din_busy(din_busy), .din_vld(din_vld),
    .din_data(din_data), .dout_busy(dout_busy),
    .dout_vld(dout_vld), .dout_data(dout_data),
    .peak(peak), .level(level)
  );

  always #5 clk = ~clk;

  function automatic int avgf(int s);
    int a;
    a = (s + 4) / 8;
    return (a > 255) ? 255 : a;
  endfunction

  // Advance one edge, updating the reference from the
  // pre-edge inputs, then settle 1 time unit.
  task automatic tick();
    bit pu;
    bit po;
    int a;
    pu = din_vld && (mq.size() < DEPTH);
    po = (mq.size() != 0) && !dout_busy;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mpk = 0;
    end else begin
      if (po) begin
        a = avgf(mq[0]);
        if (a > mpk) mpk = a;
        void'(mq.pop_front());
      end
      if (pu) mq.push_back(int'(din_data));
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din_vld = 1'b0;
    dout_busy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (level !== 3'd0) begin
      miscompares++;
      $display("FAIL rst_level got %0d want 0", level);
    end
    vectors++;
    if (peak !== 8'd0) begin
      miscompares++;
      $display("FAIL rst_peak got %0d want 0", peak);
    end
    vectors++;
    if (dout_vld !== 1'b0 || din_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_flags got vld=%b busy=%b want 0 0",
               dout_vld, din_busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    din_vld = 1'b1;
    din_data = 11'd1020;
    dout_busy = 1'b1;
    tick();
    din_vld = 1'b0;
    vectors++;
    if (dout_vld !== 1'b1 || dout_data !== 8'd128) begin
      miscompares++;
      $display("FAIL single_out got vld=%b d=%0d want 1 128",
               dout_vld, dout_data);
    end
    vectors++;
    if (level !== 3'd1) begin
      miscompares++;
      $display("FAIL single_lvl got %0d want 1", level);
    end
    dout_busy = 1'b0;
    tick();
    vectors++;
    if (level !== 3'd0 || peak !== 8'd128) begin
      miscompares++;
      $display("FAIL single_pop got lvl=%0d pk=%0d want 0 128",
               level, peak);
    end
  endtask

  task automatic test_round();
    int ins[6] = '{0, 3, 4, 12, 2043, 2047};
    int exp[6] = '{0, 0, 1, 2, 255, 255};
    int got[$];
    int i;
    int cyc;
    do_reset();
    i = 0;
    cyc = 0;
    while (got.size() < 6 && cyc < 50) begin
      din_vld = (i < 6);
      if (i < 6) din_data = 11'(ins[i]);
      if (dout_vld && !dout_busy) got.push_back(int'(dout_data));
      if (din_vld && !din_busy) i++;
      tick();
      cyc++;
    end
    din_vld = 1'b0;
    vectors++;
    if (got.size() != 6) begin
      miscompares++;
      $display("FAIL round_count got %0d want 6", got.size());
    end
    for (int k = 0; k < 6 && k < got.size(); k++) begin
      vectors++;
      if (got[k] != exp[k]) begin
        miscompares++;
        $display("FAIL round_%0d got %0d want %0d",
                 k, got[k], exp[k]);
      end
    end
    vectors++;
    if (peak !== 8'd255) begin
      miscompares++;
      $display("FAIL round_peak got %0d want 255", peak);
    end
  endtask

  task automatic test_fill();
    int w[5] = '{80, 160, 240, 320, 400};
    do_reset();
    dout_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      din_vld = 1'b1;
      din_data = 11'(w[k]);
      tick();
    end
    din_data = 11'(w[4]);
    tick();
    vectors++;
    if (level !== 3'd4 || din_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_full got lvl=%0d busy=%b want 4 1",
               level, din_busy);
    end
    vectors++;
    if (dout_data !== 8'd10) begin
      miscompares++;
      $display("FAIL fill_head got %0d want 10", dout_data);
    end
    dout_busy = 1'b0;
    tick();
    vectors++;
    if (level !== 3'd3 || din_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_pop1 got lvl=%0d busy=%b want 3 0",
               level, din_busy);
    end
    tick();
    din_vld = 1'b0;
    vectors++;
    if (level !== 3'd3) begin
      miscompares++;
      $display("FAIL fill_push5 got lvl=%0d want 3", level);
    end
    for (int k = 2; k < 5; k++) begin
      vectors++;
      if (dout_vld !== 1'b1 || dout_data !== 8'(avgf(w[k]))) begin
        miscompares++;
        $display("FAIL fill_order%0d got %0d want %0d",
                 k, dout_data, avgf(w[k]));
      end
      tick();
    end
    vectors++;
    if (level !== 3'd0 || peak !== 8'd50) begin
      miscompares++;
      $display("FAIL fill_end got lvl=%0d pk=%0d want 0 50",
               level, peak);
    end
  endtask

  task automatic test_back_to_back();
    int sb[$];
    int v;
    do_reset();
    dout_busy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      v = int'($urandom_range(0, 2047));
      din_vld = 1'b1;
      din_data = 11'(v);
      sb.push_back(avgf(v));
      tick();
    end
    dout_busy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      v = int'($urandom_range(0, 2047));
      din_data = 11'(v);
      sb.push_back(avgf(v));
      vectors++;
      if (dout_data !== 8'(sb[0])) begin
        miscompares++;
        $display("FAIL b2b_data%0d got %0d want %0d",
                 k, dout_data, sb[0]);
      end
      void'(sb.pop_front());
      tick();
      vectors++;
      if (level !== 3'd2) begin
        miscompares++;
        $display("FAIL b2b_lvl%0d got %0d want 2", k, level);
      end
    end
    din_vld = 1'b0;
    while (sb.size() > 0) begin
      vectors++;
      if (dout_vld !== 1'b1 || dout_data !== 8'(sb[0])) begin
        miscompares++;
        $display("FAIL b2b_drain got vld=%b d=%0d want 1 %0d",
                 dout_vld, dout_data, sb[0]);
      end
      void'(sb.pop_front());
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    din_vld = 1'b1;
    din_data = 11'd616;
    tick();
    din_vld = 1'b0;
    tick();
    dout_busy = 1'b1;
    din_vld = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din_data = 11'(100 + k);
      tick();
    end
    vectors++;
    if (level !== 3'd3 || peak !== 8'd77) begin
      miscompares++;
      $display("FAIL mid_pre got lvl=%0d pk=%0d want 3 77",
               level, peak);
    end
    rst = 1'b1;
    din_data = 11'd999;
    tick();
    rst = 1'b0;
    din_vld = 1'b0;
    vectors++;
    if (level !== 3'd0 || peak !== 8'd0 || dout_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_rst got lvl=%0d pk=%0d vld=%b want 0 0 0",
               level, peak, dout_vld);
    end
    tick();
    vectors++;
    if (level !== 3'd0) begin
      miscompares++;
      $display("FAIL mid_nostore got lvl=%0d want 0", level);
    end
    dout_busy = 1'b0;
  endtask

  task automatic test_random();
    int exq[$];
    int sent;
    int recv;
    int cyc;
    int emax;
    int v;
    bit pend;
    bit acc;
    do_reset();
    sent = 0;
    recv = 0;
    cyc = 0;
    emax = 0;
    pend = 1'b0;
    while ((sent < 1000 || recv < 1000) && cyc < 20000) begin
      if (!pend && sent < 1000 && $urandom_range(0, 3) != 0) begin
        v = int'($urandom_range(0, 2047));
        din_data = 11'(v);
        pend = 1'b1;
      end
      din_vld = pend;
      dout_busy = ($urandom_range(0, 2) == 0);
      vectors++;
      if (level !== 3'(mq.size()) ||
          dout_vld !== (mq.size() != 0) ||
          din_busy !== (mq.size() == DEPTH)) begin
        miscompares++;
        $display("FAIL rnd_state c%0d got lvl=%0d want %0d",
                 cyc, level, mq.size());
      end
      if (dout_vld && !dout_busy) begin
        vectors++;
        if (exq.size() == 0) begin
          miscompares++;
          $display("FAIL rnd_dup got %0d want none", dout_data);
        end else begin
          if (dout_data !== 8'(exq[0])) begin
            miscompares++;
            $display("FAIL rnd_data n%0d got %0d want %0d",
                     recv, dout_data, exq[0]);
          end
          void'(exq.pop_front());
        end
        recv++;
      end
      acc = din_vld && (mq.size() < DEPTH);
      if (acc) begin
        exq.push_back(avgf(int'(din_data)));
        if (avgf(int'(din_data)) > emax)
          emax = avgf(int'(din_data));
        sent++;
        pend = 1'b0;
      end
      tick();
      cyc++;
    end
    din_vld = 1'b0;
    vectors++;
    if (recv != 1000 || sent != 1000) begin
      miscompares++;
      $display("FAIL rnd_count got sent=%0d recv=%0d want 1000",
               sent, recv);
    end
    vectors++;
    if (peak !== 8'(emax)) begin
      miscompares++;
      $display("FAIL rnd_peak got %0d want %0d", peak, emax);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round();
    test_fill();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
